// File: rtl/uart_line_rx_if.sv
// Signal bundle between a UART byte source / line consumer and uart_line_rx.
// The slave modport is the line receiver; master is the side that feeds bytes and reads lines.
interface uart_line_rx_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       line_valid;
    logic [4:0] line_len;
    logic       match;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       line_ack;
    logic       overflow;
    logic       dropped;

    modport slave (
        input  rx_valid, rx_data, rx_error, rd_en, line_ack,
        output line_valid, line_len, match, rd_data, overflow, dropped
    );

    modport master (
        output rx_valid, rx_data, rx_error, rd_en, line_ack,
        input  line_valid, line_len, match, rd_data, overflow, dropped
    );
endinterface

// File: rtl/uart_line_rx.sv
// Assembles CR/LF-terminated lines from a UART byte stream, holds each completed
// line for byte-wise readout and flags whether it equals a fixed compare string.
module uart_line_rx #(
    parameter int          MAX_LEN   = 16,
    parameter logic [63:0] MATCH_STR = {8'h00, "ESKEDIT"},
    parameter int          MATCH_LEN = 7
) (
    input  logic           clk,
    input  logic           rst,
    uart_line_rx_if.slave  bus
);
    localparam int         IDX_W       = $clog2(MAX_LEN);
    localparam logic [4:0] MAX_LEN_L   = 5'(MAX_LEN);
    localparam logic [4:0] MATCH_LEN_L = 5'(MATCH_LEN);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, DISCARD} state_t;

    state_t     state_q, state_d;
    logic [4:0] len_q, len_d;
    logic [4:0] rd_ptr_q, rd_ptr_d;
    logic [4:0] line_len_q, line_len_d;
    logic       match_q, match_d;
    logic       overflow_q, overflow_d;
    logic       dropped_q, dropped_d;
    logic [7:0] line_buf_q [MAX_LEN];
    logic [7:0] line_buf_d [MAX_LEN];

    logic       byte_in;
    logic       is_term;
    logic       match_calc;

    // A byte arriving together with a framing error is never taken as data.
    assign byte_in = bus.rx_valid && !bus.rx_error;
    assign is_term = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);

    always_comb begin
        match_calc = (len_q == MATCH_LEN_L);
        for (int i = 0; i < MATCH_LEN; i++) begin
            if (line_buf_q[IDX_W'(i)] != MATCH_STR[8*(MATCH_LEN-1-i) +: 8]) begin
                match_calc = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rd_ptr_d   = rd_ptr_q;
        line_len_d = line_len_q;
        match_d    = match_q;
        overflow_d = 1'b0;
        dropped_d  = 1'b0;
        line_buf_d = line_buf_q;

        unique case (state_q)
            IDLE: begin
                if (byte_in && !is_term) begin
                    line_buf_d[0] = bus.rx_data;
                    len_d         = 5'd1;
                    state_d       = COLLECT;
                end
            end
            COLLECT: begin
                if (bus.rx_error) begin
                    len_d   = 5'd0;
                    state_d = IDLE;
                end else if (byte_in) begin
                    if (is_term) begin
                        line_len_d = len_q;
                        rd_ptr_d   = 5'd0;
                        match_d    = match_calc;
                        state_d    = DONE;
                    end else if (len_q < MAX_LEN_L) begin
                        line_buf_d[len_q[IDX_W-1:0]] = bus.rx_data;
                        len_d = len_q + 5'd1;
                    end else begin
                        overflow_d = 1'b1;
                        state_d    = DISCARD;
                    end
                end
            end
            DONE: begin
                if (bus.rd_en && ((rd_ptr_q + 5'd1) < line_len_q)) begin
                    rd_ptr_d = rd_ptr_q + 5'd1;
                end
                // Acknowledge frees the buffer at once, so a coincident byte starts the next line.
                if (bus.line_ack) begin
                    match_d    = 1'b0;
                    line_len_d = 5'd0;
                    len_d      = 5'd0;
                    state_d    = IDLE;
                    if (byte_in && !is_term) begin
                        line_buf_d[0] = bus.rx_data;
                        len_d         = 5'd1;
                        state_d       = COLLECT;
                    end
                end else if (byte_in) begin
                    dropped_d = 1'b1;
                end
            end
            DISCARD: begin
                if (bus.rx_error || (byte_in && is_term)) begin
                    len_d   = 5'd0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= 5'd0;
            rd_ptr_q   <= 5'd0;
            line_len_q <= 5'd0;
            match_q    <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rd_ptr_q   <= rd_ptr_d;
            line_len_q <= line_len_d;
            match_q    <= match_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // Line storage is validated by len/line_len, so it needs no reset.
    always_ff @(posedge clk) begin
        line_buf_q <= line_buf_d;
    end

    assign bus.line_valid = (state_q == DONE);
    assign bus.line_len   = line_len_q;
    assign bus.match      = match_q;
    assign bus.overflow   = overflow_q;
    assign bus.dropped    = dropped_q;
    assign bus.rd_data    = line_buf_q[rd_ptr_q[IDX_W-1:0]];
endmodule

// File: tb/tb_uart_line_rx.sv
// Directed plus randomized bench for uart_line_rx, checked against a line-level
// queue model of the receiver.
module tb_uart_line_rx;
    localparam int MAX_LEN = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_line_rx_if bus();

    uart_line_rx #(.MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: bytes of the line being received, the held line, and pulse expectations.
    logic [7:0] m_cur[$];
    logic [7:0] m_line[$];
    bit         m_held;
    bit         m_discard;
    bit         m_match;
    bit         m_ovf;
    bit         m_drop;
    int         m_rd;
    string      match_s = "ESKEDIT";

    function automatic bit is_term(logic [7:0] d);
        return (d == 8'h0D) || (d == 8'h0A);
    endfunction

    function automatic void model_reset();
        m_cur.delete();
        m_line.delete();
        m_held    = 1'b0;
        m_discard = 1'b0;
        m_match   = 1'b0;
        m_ovf     = 1'b0;
        m_drop    = 1'b0;
        m_rd      = 0;
    endfunction

    function automatic bit line_equals_match();
        if (m_line.size() != match_s.len()) return 1'b0;
        for (int i = 0; i < match_s.len(); i++) begin
            if (m_line[i] != 8'(match_s[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic void model_step(bit v, logic [7:0] d, bit e, bit rd, bit ack);
        bit ok;
        ok     = v && !e;
        m_ovf  = 1'b0;
        m_drop = 1'b0;
        if (m_held) begin
            if (rd && (m_rd < m_line.size() - 1)) m_rd++;
            if (ack) begin
                m_held  = 1'b0;
                m_match = 1'b0;
                m_cur.delete();
                if (ok && !is_term(d)) m_cur.push_back(d);
            end else if (ok) begin
                m_drop = 1'b1;
            end
        end else if (e) begin
            m_cur.delete();
            m_discard = 1'b0;
        end else if (ok) begin
            if (is_term(d)) begin
                if (m_discard) begin
                    m_discard = 1'b0;
                end else if (m_cur.size() > 0) begin
                    m_line  = m_cur;
                    m_held  = 1'b1;
                    m_rd    = 0;
                    m_match = line_equals_match();
                    m_cur.delete();
                end
            end else if (!m_discard) begin
                if (m_cur.size() == MAX_LEN) begin
                    m_ovf     = 1'b1;
                    m_discard = 1'b1;
                    m_cur.delete();
                end else begin
                    m_cur.push_back(d);
                end
            end
        end
    endfunction

    task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        cmp("line_valid", 32'(bus.line_valid), 32'(m_held));
        cmp("overflow",   32'(bus.overflow),   32'(m_ovf));
        cmp("dropped",    32'(bus.dropped),    32'(m_drop));
        if (m_held) begin
            cmp("line_len", 32'(bus.line_len), 32'(m_line.size()));
            cmp("match",    32'(bus.match),    32'(m_match));
            cmp("rd_data",  32'(bus.rd_data),  32'(m_line[m_rd]));
        end
    endtask

    task automatic applyStimulus(bit v, logic [7:0] d, bit e, bit rd, bit ack);
        @(negedge clk);
        bus.rx_valid = v;
        bus.rx_data  = d;
        bus.rx_error = e;
        bus.rd_en    = rd;
        bus.line_ack = ack;
        @(posedge clk);
        model_step(v, d, e, rd, ack);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        bus.rd_en    = 1'b0;
        bus.line_ack = 1'b0;
        checkOutput();
    endtask

    task automatic sendByte(logic [7:0] d);
        applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sendStr(string s);
        for (int i = 0; i < s.len(); i++) sendByte(8'(s[i]));
    endtask

    task automatic checkZero(string tag);
        cmp({tag, "_line_valid"}, 32'(bus.line_valid), 32'd0);
        cmp({tag, "_line_len"},   32'(bus.line_len),   32'd0);
        cmp({tag, "_match"},      32'(bus.match),      32'd0);
        cmp({tag, "_overflow"},   32'(bus.overflow),   32'd0);
        cmp({tag, "_dropped"},    32'(bus.dropped),    32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        checkZero("in_reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkZero("after_reset");
    endtask

    task automatic ackLine();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_error = 1'b0;
        bus.rd_en    = 1'b0;
        bus.line_ack = 1'b0;
        model_reset();

        doReset();

        $display("[TB] matching line and readout");
        sendStr("ESKEDIT");
        sendByte(8'h0D);
        cmp("eskedit_len",   32'(bus.line_len), 32'd7);
        cmp("eskedit_match", 32'(bus.match),    32'd1);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        cmp("rd_hold_last", 32'(bus.rd_data), 32'h54);
        ackLine();

        $display("[TB] non-matching line");
        sendStr("ESKEDI");
        sendByte(8'h0A);
        cmp("eskedi_match", 32'(bus.match), 32'd0);
        ackLine();
        cmp("ack_clears_valid", 32'(bus.line_valid), 32'd0);

        $display("[TB] overflow");
        for (int i = 0; i < 17; i++) sendByte(8'h41);
        cmp("overflow_pulse", 32'(bus.overflow), 32'd1);
        sendByte(8'h0D);
        cmp("overflow_no_line", 32'(bus.line_valid), 32'd0);
        sendStr("X");
        sendByte(8'h0D);
        cmp("after_overflow_len", 32'(bus.line_len), 32'd1);
        ackLine();

        $display("[TB] dropped and ack-with-byte");
        sendStr("AB");
        sendByte(8'h0D);
        sendByte(8'h43);
        cmp("dropped_pulse", 32'(bus.dropped), 32'd1);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b1);
        cmp("ack_byte_no_drop", 32'(bus.dropped), 32'd0);
        sendByte(8'h0D);
        cmp("next_line_d", 32'(bus.rd_data), 32'h44);
        ackLine();

        $display("[TB] framing error abort");
        sendStr("AB");
        applyStimulus(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        sendStr("CD");
        sendByte(8'h0D);
        cmp("err_abort_len", 32'(bus.line_len), 32'd2);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        ackLine();

        $display("[TB] reset mid-line");
        sendStr("ABC");
        doReset();
        sendStr("Q");
        sendByte(8'h0D);
        cmp("post_reset_first", 32'(bus.rd_data), 32'h51);
        ackLine();

        $display("[TB] randomized traffic");
        for (int k = 0; k < 600; k++) begin
            int         r;
            logic [7:0] d;
            r = $urandom_range(0, 99);
            if (r < 12)      d = 8'h0D;
            else if (r < 16) d = 8'h0A;
            else             d = 8'(8'h41 + $urandom_range(0, 5));
            if (k % 97 == 0) begin
                sendStr("ESKEDIT");
                sendByte(8'h0A);
            end
            applyStimulus(($urandom_range(0, 3) != 0), d,
                          ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 1) == 1),
                          ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_line_rx.md
UART_LINE_RX -- requirements
Module: uart_line_rx

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the line buffer depth in bytes (range 2..31).
REQ-002 Parameter MATCH_STR, default 64-bit "ESKEDIT", SHALL hold the compare string, right-justified, last character in bits [7:0].
REQ-003 Parameter MATCH_LEN, default 7, SHALL set the number of valid characters in MATCH_STR (range 1..8, at most MAX_LEN).
REQ-004 Port: clk, input, 1, the single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 Port: rst, input, 1, synchronous active-high reset.
REQ-006 Port: rx_valid, input, 1, one-cycle pulse, rx_data is valid (the UART "received" strobe).
REQ-007 Port: rx_data, input, 8, received byte.
REQ-008 Port: rx_error, input, 1, one-cycle pulse, UART framing error.
REQ-009 Port: line_valid, output, 1, level, a completed line is held for readout.
REQ-010 Port: line_len, output, 5, byte count of the held line, terminator excluded.
REQ-011 Port: match, output, 1, level, held line equals MATCH_STR; meaningful only while line_valid=1.
REQ-012 Port: rd_en, input, 1, advance the read pointer by one byte.
REQ-013 Port: rd_data, output, 8, combinational buffer byte at the read pointer.
REQ-014 Port: line_ack, input, 1, release the held line.
REQ-015 Port: overflow, output, 1, one-cycle pulse, line exceeded MAX_LEN.
REQ-016 Port: dropped, output, 1, one-cycle pulse, byte lost while a line was held.

Function
REQ-017 Terminators SHALL be CR (0x0D) and LF (0x0A); all other bytes are data.
REQ-018 The FSM SHALL have exactly four states: IDLE, COLLECT, DONE, DISCARD.
REQ-019 IDLE: a terminator SHALL be ignored (no empty lines).
REQ-020 IDLE: a data byte SHALL be written to buf[0], set len=1, and go to COLLECT.
REQ-021 COLLECT: a data byte with len<MAX_LEN SHALL be written to buf[len] and increment len.
REQ-022 COLLECT: a data byte with len=MAX_LEN SHALL pulse overflow the next cycle and go to DISCARD; the buffer content is then don't-care.
REQ-023 COLLECT: a terminator SHALL go to DONE and set line_valid=1 on the following cycle.
REQ-024 On entry to DONE, line_len=len and the read pointer=0.
REQ-025 On entry to DONE, match SHALL be registered as 1 iff len=MATCH_LEN and buf[i] equals the MATCH_STR character i for all i, where character i is bits [8*(MATCH_LEN-1-i)+7 : 8*(MATCH_LEN-1-i)].
REQ-026 DISCARD: data bytes SHALL be ignored; a terminator SHALL go to IDLE with no line_valid.
REQ-027 rx_error in COLLECT or DISCARD SHALL abort the line and go to IDLE with len=0.
REQ-028 rx_error in IDLE or DONE SHALL have no effect; rx_valid is ignored in any cycle where rx_error=1.
REQ-029 DONE: each rd_en SHALL increment the read pointer.
REQ-030 DONE: at pointer=line_len-1 the read pointer SHALL hold; it SHALL NOT wrap.
REQ-031 DONE: rd_en SHALL be ignored outside DONE.
REQ-032 DONE: rx_valid without line_ack SHALL drop the byte and pulse dropped on the next cycle.
REQ-033 DONE: line_ack SHALL go to IDLE and clear line_valid and match the next cycle.
REQ-034 DONE: if line_ack and rx_valid coincide, the byte SHALL be processed with IDLE rules in the same cycle, with no dropped pulse.
REQ-035 rd_data SHALL equal buf[rd_ptr] with zero latency; its value outside DONE is don't-care.
REQ-036 End-to-end latency SHALL be one clock: a terminator on rx_valid in cycle N gives line_valid=1 in cycle N+1.

Reset
REQ-037 While rst=1 and on the first cycle after reset, the FSM SHALL be in IDLE and line_valid, match, overflow, dropped, line_len, len and rd_ptr SHALL be 0.
REQ-038 Reset asserted mid-line or while holding SHALL discard all line content; buffer storage need not be cleared.

Verification
REQ-039 Bytes "ESKEDIT",0x0D -> one cycle later line_valid=1, line_len=7, match=1; 7 rd_en give rd_data 0x45,0x53,0x4B,0x45,0x44,0x49,0x54.
REQ-040 Bytes "ESKEDI",0x0A -> line_valid=1, line_len=6, match=0; then line_ack -> line_valid=0 next cycle.
REQ-041 With MAX_LEN=16: 17 bytes 'A' then 0x0D -> overflow pulses once after the 17th byte and line_valid stays 0; a following "X",0x0D -> line_len=1.
REQ-042 Holding "AB": byte 'C' alone -> dropped=1 for one cycle; then line_ack in the same cycle as 'D' -> no dropped pulse, and the next line starts with 'D'.
REQ-043 "AB", rx_error, "CD",0x0D -> line_len=2 with data "CD"; separately, rst during "ABC" -> all outputs 0 and the next line starts at buf[0].
